// File: rtl/xxhash64_feeder.sv
// xxhash64_feeder: packs an upstream byte stream into 64-bit little-endian
// words and drives an XXH64 core through seed / add / request strobes,
// returning the digest on a valid/ready result channel.
// Optional build macro XXH_FEED_PAD_EN: when defined, a partial final word is
// zero-padded and hashed; when undefined, the partial tail is dropped and
// flagged on tail_dropped.
module xxhash64_feeder #(
   parameter int unsigned REQ_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   input  logic [63:0] seed,
   output logic        hash_seed,
   output logic        hash_add,
   output logic        hash_request,
   output logic [63:0] hash_word,
   input  logic        hash_ready_in,
   input  logic [63:0] hash_in,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] m_hash,
   output logic [31:0] m_bytes,
   output logic        m_error,
   output logic        tail_dropped
);

   localparam int unsigned TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(REQ_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_FILL,
      ST_FLUSH,
      ST_REQ,
      ST_OUT
   } state_e;

   state_e        state_q, state_d;
   logic [63:0]   lanes_q, lanes_d;
   logic [2:0]    lane_q, lane_d;
   logic [63:0]   word_q, word_d;
   logic          add_q, add_d;
   logic [31:0]   bytes_q, bytes_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [63:0]   hash_q, hash_d;
   logic          err_q, err_d;
   logic          drop_q, drop_d;
   logic          req_expired;

   assign req_expired = (tmo_q == TMO_LAST) && !hash_ready_in;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (s_valid) state_d = ST_SEED;
         ST_SEED:  state_d = ST_FILL;
         ST_FILL:  if (s_valid && s_last) state_d = ST_FLUSH;
         // FLUSH lasts until the lane counter is zero, so any word it emits
         // (or a full last word from FILL) has its hash_add cycle before REQ.
         ST_FLUSH: if (lane_q == 3'd0) state_d = ST_REQ;
         ST_REQ:   if (hash_ready_in || req_expired) state_d = ST_OUT;
         ST_OUT:   if (m_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: lane packing, word strobe, counters, result capture
   always_comb begin
      lanes_d = lanes_q;
      lane_d  = lane_q;
      word_d  = word_q;
      add_d   = 1'b0;
      bytes_d = bytes_q;
      tmo_d   = '0;
      hash_d  = hash_q;
      err_d   = err_q;
      drop_d  = drop_q;
      unique case (state_q)
         ST_IDLE: begin
            // Seed goes into the word register so hash_word shows it in SEED
            if (s_valid) word_d = seed;
         end
         ST_SEED: begin
            lanes_d = '0;
            lane_d  = '0;
            bytes_d = '0;
            err_d   = 1'b0;
            drop_d  = 1'b0;
         end
         ST_FILL: begin
            if (s_valid) begin
               lanes_d[{lane_q, 3'b000} +: 8] = s_data;
               lane_d  = lane_q + 3'd1;
               bytes_d = bytes_q + 32'd1;
               if (lane_q == 3'd7) begin
                  word_d  = lanes_d;
                  add_d   = 1'b1;
                  lanes_d = '0;
               end
            end
         end
         ST_FLUSH: begin
            if (lane_q != 3'd0) begin
`ifdef XXH_FEED_PAD_EN
               word_d = lanes_q;
               add_d  = 1'b1;
`else
               drop_d = 1'b1;
`endif
               lanes_d = '0;
               lane_d  = '0;
            end
         end
         ST_REQ: begin
            tmo_d = tmo_q + 1'b1;
            if (hash_ready_in) begin
               hash_d = hash_in;
               err_d  = 1'b0;
            end else if (req_expired) begin
               hash_d = '0;
               err_d  = 1'b1;
            end
         end
         ST_OUT: begin
         end
         default: begin
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lanes_q <= '0;
         lane_q  <= '0;
         word_q  <= '0;
         add_q   <= 1'b0;
         bytes_q <= '0;
         tmo_q   <= '0;
         hash_q  <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         lanes_q <= lanes_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         add_q   <= add_d;
         bytes_q <= bytes_d;
         tmo_q   <= tmo_d;
         hash_q  <= hash_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   // Output decode from state and registers
   always_comb begin
      s_ready      = (state_q == ST_FILL);
      hash_seed    = (state_q == ST_SEED);
      hash_request = (state_q == ST_REQ);
      m_valid      = (state_q == ST_OUT);
      hash_add     = add_q;
      hash_word    = word_q;
      m_hash       = hash_q;
      m_bytes      = bytes_q;
      m_error      = err_q;
      tail_dropped = drop_q;
   end

endmodule

// File: tb/tb_xxhash64_feeder.sv
// Self-checking bench for xxhash64_feeder: scoreboarded seed/word strobes and
// results, with a behavioural hash-core responder.
module tb_xxhash64_feeder;

   localparam int unsigned TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic [63:0] seed;
   logic        hash_seed;
   logic        hash_add;
   logic        hash_request;
   logic [63:0] hash_word;
   logic        hash_ready_in;
   logic [63:0] hash_in;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_hash;
   logic [31:0] m_bytes;
   logic        m_error;
   logic        tail_dropped;

   typedef struct {
      logic [63:0] word;
      int          gap;
   } word_t;

   typedef struct {
      logic [63:0] hash;
      logic [31:0] bytes;
      logic        err;
      logic        tdrop;
   } res_t;

   logic [63:0] seed_exp[$];
   word_t       word_exp[$];
   res_t        res_exp[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_add = 0;
   int          n_seed   = 0;

   bit          core_en    = 1'b1;
   int          core_delay = 2;
   logic [63:0] core_val   = 64'h0;

   xxhash64_feeder #(.REQ_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .seed         (seed),
      .hash_seed    (hash_seed),
      .hash_add     (hash_add),
      .hash_request (hash_request),
      .hash_word    (hash_word),
      .hash_ready_in(hash_ready_in),
      .hash_in      (hash_in),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_hash       (m_hash),
      .m_bytes      (m_bytes),
      .m_error      (m_error),
      .tail_dropped (tail_dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Hash core model: answers a request after core_delay cycles, junk otherwise
   initial begin
      int req_cnt;
      req_cnt       = 0;
      hash_ready_in = 1'b0;
      hash_in       = 64'h0;
      forever begin
         @(negedge clk);
         if (hash_request) req_cnt++;
         else req_cnt = 0;
         hash_ready_in = core_en && hash_request && (req_cnt > core_delay);
         hash_in       = hash_ready_in ? core_val : ~core_val;
      end
   end

   // Strobe monitor: seed and word pulses against expected queues
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         if (hash_seed) begin
            n_seed++;
            if (seed_exp.size() == 0) check("seed_unexpected", 64'd1, 64'd0);
            else check("seed_word", hash_word, seed_exp.pop_front());
         end
         if (hash_add) begin
            check("add_vs_req", 64'(hash_request), 64'd0);
            if (word_exp.size() == 0) begin
               check("add_unexpected", 64'd1, 64'd0);
            end else begin
               e = word_exp.pop_front();
               check("add_word", hash_word, e.word);
               if (e.gap != 0) check("add_gap", 64'(cyc - last_add), 64'(e.gap));
            end
            last_add = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs();
      check("rst_s_ready",      64'(s_ready),      64'd0);
      check("rst_hash_seed",    64'(hash_seed),    64'd0);
      check("rst_hash_add",     64'(hash_add),     64'd0);
      check("rst_hash_request", 64'(hash_request), 64'd0);
      check("rst_hash_word",    hash_word,         64'd0);
      check("rst_m_valid",      64'(m_valid),      64'd0);
      check("rst_m_hash",       m_hash,            64'd0);
      check("rst_m_bytes",      64'(m_bytes),      64'd0);
      check("rst_m_error",      64'(m_error),      64'd0);
      check("rst_tail_dropped", 64'(tail_dropped), 64'd0);
   endtask

   task automatic push_expect(input int n, input logic [7:0] first);
      logic [63:0] w;
      word_t       e;
      res_t        r;
      int          full;
      w    = '0;
      full = 0;
      for (int i = 0; i < n; i++) begin
         w[8*(i%8) +: 8] = first + 8'(i);
         if (i % 8 == 7) begin
            e.word = w;
            e.gap  = (full > 0) ? 8 : 0;
            word_exp.push_back(e);
            full++;
            w = '0;
         end
      end
`ifdef XXH_FEED_PAD_EN
      if (n % 8 != 0) begin
         e.word = w;
         e.gap  = 0;
         word_exp.push_back(e);
      end
      r.tdrop = 1'b0;
`else
      r.tdrop = (n % 8 != 0);
`endif
      r.bytes = 32'(n);
      r.err   = !core_en;
      r.hash  = core_en ? core_val : 64'h0;
      res_exp.push_back(r);
   endtask

   task automatic drive_bytes(input int n, input logic [7:0] first, input bit with_last);
      int i;
      int g;
      bit hs;
      i = 0;
      g = 0;
      while (i < n && g < 200) begin
         s_valid = 1'b1;
         s_data  = first + 8'(i);
         s_last  = with_last && (i == n - 1);
         hs      = s_ready;
         @(negedge clk);
         if (hs) i++;
         g++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (i < n) check("byte_accept_timeout", 64'(i), 64'(n));
   endtask

   task automatic wait_result(input int hold, input bit tmo_case);
      int          g;
      int          t0;
      logic [63:0] h0;
      res_t        r;
      g = 0;
      while (!hash_request && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("req_seen", 64'(hash_request), 64'd1);
      t0 = cyc;
      g  = 0;
      while (!m_valid && g < int'(TMO) + 50) begin
         @(negedge clk);
         g++;
      end
      if (!m_valid) begin
         check("result_seen", 64'd0, 64'd1);
         return;
      end
      if (tmo_case) check("tmo_latency", 64'(cyc - t0), 64'(TMO));
      h0 = m_hash;
      for (int k = 0; k < hold; k++) begin
         check("hold_valid",  64'(m_valid), 64'd1);
         check("hold_hash",   m_hash,       h0);
         check("hold_sready", 64'(s_ready), 64'd0);
         @(negedge clk);
      end
      if (res_exp.size() == 0) begin
         check("result_unexpected", 64'd1, 64'd0);
      end else begin
         r = res_exp.pop_front();
         check("m_hash",       m_hash,            r.hash);
         check("m_bytes",      64'(m_bytes),      64'(r.bytes));
         check("m_error",      64'(m_error),      64'(r.err));
         check("tail_dropped", 64'(tail_dropped), 64'(r.tdrop));
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("idle_after_ack",   64'(m_valid), 64'd0);
      check("sready_after_ack", 64'(s_ready), 64'd0);
   endtask

   task automatic run_msg(input int n, input logic [7:0] first, input logic [63:0] sd, input int hold);
      seed = sd;
      seed_exp.push_back(sd);
      push_expect(n, first);
      drive_bytes(n, first, 1'b1);
      wait_result(hold, !core_en);
   endtask

   initial begin
      int n0;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      seed    = 64'h0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // single full word, seed 0
      core_en = 1'b1; core_delay = 2; core_val = 64'h0123_4567_89AB_CDEF;
      run_msg(8, 8'h01, 64'h0, 0);

      // four back-to-back words
      core_val = 64'hFEED_FACE_CAFE_BEEF;
      run_msg(32, 8'h10, 64'h1122_3344_5566_7788, 0);

      // 11 bytes: partial tail
      core_delay = 0; core_val = 64'h5A5A_0000_1234_A5A5;
      run_msg(11, 8'h01, 64'h0BAD_F00D_0000_0001, 0);

      // core never answers: timeout
      core_en = 1'b0;
      run_msg(3, 8'hA0, 64'hDEAD_BEEF_0000_0003, 0);
      core_en = 1'b1;

      // result held for 10 cycles with m_ready low
      core_delay = 1; core_val = 64'h1357_9BDF_2468_ACE0;
      run_msg(9, 8'h55, 64'h7777_0000_7777_0000, 10);

      // reset one cycle after the 5th byte
      seed = 64'hABCD_0000_0000_0005;
      seed_exp.push_back(seed);
      drive_bytes(5, 8'h40, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      n0 = n_seed;
      core_val = 64'h0F0F_0F0F_F0F0_F0F0;
      run_msg(8, 8'h80, 64'h9999_8888_7777_6666, 0);
      check("fresh_seed_pulse", 64'(n_seed - n0), 64'd1);

      // random messages
      for (int m = 0; m < 12; m++) begin
         core_delay = int'($urandom_range(0, 5));
         core_val   = {$urandom, $urandom};
         run_msg(int'($urandom_range(1, 20)), 8'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      check("seed_queue_drained",   64'(seed_exp.size()), 64'd0);
      check("word_queue_drained",   64'(word_exp.size()), 64'd0);
      check("result_queue_drained", 64'(res_exp.size()),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xxhash64_feeder.md
XXHASH64_FEEDER -- requirements
Module: xxhash64_feeder

Interface
REQ-001 Parameter REQ_TIMEOUT, default 64: maximum cycles in REQ waiting for hash_ready_in before abort.
REQ-002 Port clk  input  1  sole clock; all logic on posedge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port s_valid / s_ready / s_data / s_last  in / out / in[8] / in  upstream byte stream; s_last marks final byte of message.
REQ-005 Port seed  input  64  per-message seed.
REQ-006 Port hash_seed / hash_add / hash_request  output  1 each  drive hash core seed_in / add_to_hash / request_hash.
REQ-007 Port hash_word  output  64  drives hash core input_bytes (seed or data word).
REQ-008 Port hash_ready_in / hash_in  input  1 / 64  hash core hash_ready / output_hash.
REQ-009 Port m_valid / m_ready / m_hash / m_bytes / m_error / tail_dropped  out / in / out[64] / out[32] / out / out  result channel.

Function
REQ-010 FSM states IDLE, SEED, FILL, FLUSH, REQ, OUT; exactly one active per cycle.
REQ-011 IDLE: s_ready=0; s_valid=1 -> SEED, seed sampled that cycle, byte not consumed.
REQ-012 SEED: one cycle, hash_seed=1, hash_word=sampled seed, byte/lane counters cleared -> FILL.
REQ-013 FILL: s_ready=1; each handshake writes s_data to lane L (bits 8L+7:8L), little-endian, first byte lane 0; L increments mod 8; m_bytes increments by 1.
REQ-014 Lane 7 written -> registered hash_add=1 for exactly one cycle the following cycle, hash_word=packed word; lane register cleared to zero.
REQ-015 hash_add never asserted on consecutive cycles; at one byte/cycle minimum spacing is 8 cycles.
REQ-016 s_last with word complete -> REQ after the hash_add cycle.
REQ-017 s_last with 1-7 lanes filled -> FLUSH (behaviour per REQ-027/028).
REQ-018 REQ: hash_request held 1, hash_add=0, until hash_ready_in=1; that cycle hash_in captured into m_hash -> OUT.
REQ-019 REQ entered only after hash_add has deasserted; hash_request and hash_add never both 1.
REQ-020 REQ cycle counter reaching REQ_TIMEOUT without hash_ready_in -> OUT with m_error=1, m_hash=0.
REQ-021 OUT: m_valid=1; m_hash, m_bytes, m_error, tail_dropped stable until m_ready=1; handshake -> IDLE, m_valid=0 next cycle.
REQ-022 s_ready=0 in every state except FILL.
REQ-023 m_bytes wraps modulo 2^32; no saturation.
REQ-024 hash_word holds last driven value when hash_seed and hash_add both 0.

Reset
REQ-025 rst_n=0 at a posedge: state IDLE; all outputs 0 (s_ready, hash_seed, hash_add, hash_request, hash_word, m_valid, m_hash, m_bytes, m_error, tail_dropped); counters and partial word cleared.
REQ-026 Reset mid-message discards partial data; hash core not notified; next message re-seeds via SEED.

Configuration
REQ-027 XXH_FEED_PAD_EN defined: FLUSH emits one hash_add with unfilled lanes zero, tail_dropped=0, then -> REQ.
REQ-028 XXH_FEED_PAD_EN undefined: FLUSH emits no word, discards partial lanes, sets tail_dropped=1, -> REQ; m_bytes still counts dropped bytes.

Verification
REQ-029 Seed 0, bytes 0x01..0x08, s_last on 8th -> one hash_seed pulse, one hash_add with hash_word=0x0807060504030201, then hash_request; m_bytes=8, m_error=0.
REQ-030 32 bytes back-to-back -> four hash_add pulses exactly 8 cycles apart, none coincident with hash_request.
REQ-031 Bytes 0x01..0x0B, PAD_EN defined -> second hash_word=0x00000000000B0A09, m_bytes=11, tail_dropped=0; undefined -> one hash_add, tail_dropped=1, m_bytes=11.
REQ-032 hash_ready_in tied 0 -> m_valid asserted 64 cycles after REQ entry, m_error=1, m_hash=0.
REQ-033 rst_n=0 one cycle after 5th byte of FILL -> next cycle all outputs 0, state IDLE; following message produces fresh hash_seed pulse.
REQ-034 m_ready held 0 for 10 cycles in OUT -> m_valid, m_hash stable, s_ready=0 throughout; IDLE cycle after m_ready=1.
